// File: rtl/keygen_pkg.sv
// Shared types and constants for the round-key schedule controller.
package keygen_pkg;

   localparam int unsigned KEY_W  = 64;
   localparam int unsigned HALF_W = 32;

   localparam logic ALU_ADD = 1'b1;
   localparam logic ALU_SUB = 1'b0;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADD  = 3'd1,
      S_SUB  = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/ALU64bit.sv
// Shared 64-bit add/subtract unit; sel=1 adds, sel=0 subtracts, carry discarded.
module ALU64bit (
   output logic [63:0] out,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        sel
);

   assign out = sel ? (a + b) : (a - b);

endmodule

// File: rtl/keygen_sched.sv
// Key-schedule controller: time-multiplexes one ALU64bit to produce NUM_ROUNDS
// (sum, difference) round-key pairs, handed out over a valid/ready interface.
module keygen_sched
   import keygen_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 4,
   parameter int unsigned ROUND_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [63:0]        key,
   output logic               busy,
   output logic [63:0]        key1,
   output logic [63:0]        key2,
   output logic [ROUND_W-1:0] round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               done
);

   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   state_e             state_q;
   logic [KEY_W-1:0]   key_q;
   logic [KEY_W-1:0]   key1_q;
   logic [KEY_W-1:0]   key2_q;
   logic [ROUND_W-1:0] round_q;
   logic               out_valid_q;
   logic               done_q;

   logic [KEY_W-1:0]   left;
   logic [KEY_W-1:0]   right;
   logic [KEY_W-1:0]   alu_out;
   logic               alu_sel;
   logic [KEY_W-1:0]   key_d;

   assign left    = {{HALF_W{key_q[KEY_W-1]}}, key_q[KEY_W-1:HALF_W]};
   assign right   = {{HALF_W{key_q[HALF_W-1]}}, key_q[HALF_W-1:0]};
   assign alu_sel = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;

   ALU64bit u_alu (
      .out (alu_out),
      .a   (left),
      .b   (right),
      .sel (alu_sel)
   );

   // Next round key is built from the low halves of the pair just accepted.
   assign key_d = {key1_q[HALF_W-1:0], key2_q[HALF_W-1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         key1_q      <= '0;
         key2_q      <= '0;
         round_q     <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  key_q   <= key;
                  round_q <= '0;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               key1_q  <= alu_out;
               state_q <= S_SUB;
            end
            S_SUB: begin
               key2_q      <= alu_out;
               out_valid_q <= 1'b1;
               state_q     <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (round_q == LAST_ROUND) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     key_q   <= key_d;
                     round_q <= round_q + ROUND_W'(1);
                     state_q <= S_ADD;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign key1      = key1_q;
   assign key2      = key2_q;
   assign round     = round_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_keygen_sched.sv
// Scoreboard bench for keygen_sched: expected pairs are queued at start and
// compared at each handshake, with latency, backpressure and reset checks.
module tb_keygen_sched;

   localparam int unsigned NR = 4;
   localparam int unsigned RW = 4;

   typedef struct packed {
      logic [RW-1:0] rnd;
      logic [63:0]   k1;
      logic [63:0]   k2;
   } pair_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [63:0]   key = '0;
   logic          out_ready = 1'b1;
   logic          busy;
   logic [63:0]   key1;
   logic [63:0]   key2;
   logic [RW-1:0] round;
   logic          out_valid;
   logic          done;

   pair_t         sb[$];
   int unsigned   n_chk = 0;
   int unsigned   n_fail = 0;
   logic [63:0]   obs_k1 [NR];
   logic [63:0]   obs_k2 [NR];

   keygen_sched #(
      .NUM_ROUNDS (NR),
      .ROUND_W    (RW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
      .busy      (busy),
      .key1      (key1),
      .key2      (key2),
      .round     (round),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic void model_push(input logic [63:0] k_in);
      logic [63:0] k, l, r, s, d;
      k = k_in;
      for (int i = 0; i < int'(NR); i++) begin
         l = {{32{k[63]}}, k[63:32]};
         r = {{32{k[31]}}, k[31:0]};
         s = l + r;
         d = l - r;
         sb.push_back('{rnd: RW'(i), k1: s, k2: d});
         k = {s[31:0], d[31:0]};
      end
   endfunction

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_key1"}, key1, 64'h0);
      chk({tag, "_key2"}, key2, 64'h0);
      chk({tag, "_round"}, 64'(round), 64'h0);
      chk({tag, "_valid"}, 64'(out_valid), 64'h0);
      chk({tag, "_done"}, 64'(done), 64'h0);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
   endtask

   task automatic wait_valid(output int unsigned cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
      end while (!out_valid && cyc < 20);
   endtask

   task automatic run_sched(input logic [63:0] k, input int stall_rnd, input int abort_rnd);
      pair_t       exp;
      int unsigned cyc;
      int unsigned dcnt;
      model_push(k);
      @(negedge clk);
      start     = 1'b1;
      key       = k;
      out_ready = 1'b1;
      for (int r = 0; r < int'(NR); r++) begin
         if (r == abort_rnd) begin
            @(negedge clk);
            chk("abort_busy_in_sub", 64'(busy), 64'h1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk_idle_zero("abort");
            sb.delete();
            dcnt = 0;
            repeat (4) begin
               @(negedge clk);
               dcnt += 32'(done);
            end
            chk("abort_no_done", 64'(dcnt), 64'h0);
            chk("abort_stays_idle", 64'(busy), 64'h0);
            return;
         end
         wait_valid(cyc);
         key = {$urandom, $urandom};
         chk("latency", 64'(cyc), (r == 0) ? 64'd3 : 64'd2);
         if (!out_valid) begin
            chk("valid_timeout", 64'(out_valid), 64'h1);
            sb.delete();
            return;
         end
         exp = sb.pop_front();
         if (r == stall_rnd) begin
            out_ready = 1'b0;
            repeat (10) begin
               @(negedge clk);
               start = 1'b1;
               key   = 64'hDEAD_BEEF_1234_5678;
               chk("stall_key1", key1, exp.k1);
               chk("stall_key2", key2, exp.k2);
               chk("stall_round", 64'(round), 64'(exp.rnd));
               chk("stall_valid", 64'(out_valid), 64'h1);
            end
            start     = 1'b0;
            out_ready = 1'b1;
         end
         chk("key1", key1, exp.k1);
         chk("key2", key2, exp.k2);
         chk("round", 64'(round), 64'(exp.rnd));
         obs_k1[r] = key1;
         obs_k2[r] = key2;
         @(negedge clk);
         chk("valid_drop", 64'(out_valid), 64'h0);
      end
      dcnt = 32'(done);
      chk("busy_in_done", 64'(busy), 64'h1);
      start = 1'b1;
      key   = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      start = 1'b0;
      dcnt += 32'(done);
      chk("start_in_done_ignored", 64'(busy), 64'h0);
      @(negedge clk);
      dcnt += 32'(done);
      chk("done_pulses", 64'(dcnt), 64'h1);
      chk("idle_after_done", 64'(busy), 64'h0);
      chk("sb_empty", 64'(sb.size()), 64'h0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_idle_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_sched(64'h0000_0005_0000_0003, -1, -1);
      chk("basic_r0_key1", obs_k1[0], 64'h8);
      chk("basic_r0_key2", obs_k2[0], 64'h2);
      chk("chain_r1_key1", obs_k1[1], 64'hA);
      chk("chain_r1_key2", obs_k2[1], 64'h6);

      run_sched(64'hFFFF_FFFF_0000_0001, -1, -1);
      chk("sext_key1", obs_k1[0], 64'h0);
      chk("sext_key2", obs_k2[0], 64'hFFFF_FFFF_FFFF_FFFE);

      run_sched(64'h7FFF_FFFF_8000_0000, -1, -1);
      chk("wrap_key1", obs_k1[0], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("wrap_key2", obs_k2[0], 64'h0000_0000_FFFF_FFFF);

      run_sched({$urandom, $urandom}, 1, -1);
      run_sched({$urandom, $urandom}, -1, 2);

      run_sched(64'h0000_0005_0000_0003, -1, -1);
      chk("post_reset_key1", obs_k1[0], 64'h8);
      repeat (5) @(negedge clk);
      chk("hold_key1", key1, obs_k1[NR-1]);
      chk("hold_key2", key2, obs_k2[NR-1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/keygen_sched.md
Name: keygen_sched

Overview:
- Sequential key-schedule controller that time-multiplexes a single shared ALU64bit instance to produce NUM_ROUNDS pairs of 64-bit round keys from one 64-bit master key.
- Each round computes key1 = left + right and key2 = left - right, where left and right are the sign-extended 32-bit halves of the current round key.
- The next round key is derived from the current pair.
- Sits between the key register/loader and the cipher datapath, which consumes keys through a valid/ready handshake.

Parameters:
- NUM_ROUNDS, 4, number of key pairs generated per start (legal range 1..16).
- ROUND_W, 4, width of round index output; must satisfy 2**ROUND_W >= NUM_ROUNDS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a new schedule; sampled only in IDLE.
- key  input  64  master key; sampled on the accepted start cycle.
- busy  output  1  high in any state other than IDLE.
- key1  output  64  round key, sum result; valid while out_valid.
- key2  output  64  round key, difference result; valid while out_valid.
- round  output  ROUND_W  index of the pair on key1/key2, 0-based.
- out_valid  output  1  round key pair available.
- out_ready  input  1  consumer accepts the pair when out_valid && out_ready.
- done  output  1  single-cycle pulse after the last pair is accepted.

Behaviour:
- Reset: clk and a synchronous active-low rst_n; reset is checked at the rising edge only.
  - While rst_n=0 at an edge: state=IDLE; key_q, key1, key2, round all 0; out_valid=0, done=0, busy=0.
  - Reset mid-schedule aborts the schedule with no done pulse.
- Halves (combinational from key_q):
  - left = {{32{key_q[63]}}, key_q[63:32]}
  - right = {{32{key_q[31]}}, key_q[31:0]}
- ALU: one ALU64bit instance with operands a=left, b=right. Op select 1'b1 = add, 1'b0 = subtract. The select is driven by the FSM: 1 in ADD, 0 otherwise.
- Arithmetic: 64-bit modular; carry and overflow are discarded.
- FSM states and transitions:
  - IDLE: if start, then key_q<=key, round<=0, go to ADD. Otherwise stay.
  - ADD: key1<=alu_out (sum); go to SUB.
  - SUB: key2<=alu_out (difference); go to EMIT.
  - EMIT: out_valid=1, with key1, key2 and round held stable.
    - If out_ready is low, stay in EMIT indefinitely.
    - On handshake with round==NUM_ROUNDS-1: go to DONE.
    - On handshake otherwise: key_q<={key1[31:0], key2[31:0]}, round<=round+1, go to ADD.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Latency:
  - First out_valid is visible 3 cycles after the start edge (start edge, ADD edge, SUB edge).
  - Steady state is 3 cycles per round when out_ready is held high.
- out_valid is registered and deasserts in the cycle after the handshake.
- start is ignored when not in IDLE, including the DONE cycle. start in the cycle after DONE is accepted.
- key may change freely after the start cycle; the schedule uses only key_q.
- key1/key2 keep their last values after completion until the next schedule overwrites them.
- NUM_ROUNDS=1: ADD, SUB, one EMIT, then DONE.

Decomposition:
- Shared package keygen_pkg:
  - state encoding constants S_IDLE, S_ADD, S_SUB, S_EMIT, S_DONE (3-bit).
  - ALU_ADD=1'b1, ALU_SUB=1'b0.
  - KEY_W=64, HALF_W=32.
- Sub-module: reuse the existing ALU64bit (ports: out, a, b, sel) as the single shared instance; no new sub-module.
- FSM, key_q, result registers and round counter live in keygen_sched.

Test Plan:
- Basic round 0: key=64'h0000_0005_0000_0003, start, out_ready=1.
  - Expect key1=64'h8 and key2=64'h2 with round=0.
  - out_valid must appear on the 3rd edge after start.
- Chaining: continue the basic test.
  - Round 1 key_q=64'h0000_0008_0000_0002 gives key1=64'hA and key2=64'h6.
  - After 4 handshakes, done pulses exactly once, then busy=0.
- Sign extension: key=64'hFFFF_FFFF_0000_0001.
  - Expect key1=64'h0 and key2=64'hFFFF_FFFF_FFFF_FFFE.
- Wrap/overflow: key=64'h7FFF_FFFF_8000_0000.
  - Expect key1=64'hFFFF_FFFF_FFFF_FFFF and key2=64'h0000_0000_FFFF_FFFF.
- Backpressure and ignored start: hold out_ready=0 for 10 cycles in EMIT while pulsing start with a different key.
  - key1, key2, round and out_valid stay stable.
  - The schedule is unchanged once ready rises.
- Reset mid-op: drive rst_n=0 for one edge during SUB of round 2.
  - Next cycle all outputs are 0 and state is IDLE, with no done pulse.
  - A new start runs normally from round 0.
